// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment readback decoder.
//   - segment bit indices (bit0 = a ... bit6 = g, 1 = lit)
//   - blank pattern and the 16-entry hex code table
//   - seg7_to_hex(): pattern -> {legal, digit[3:0]}
//   - sequence FSM state type
package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Entry i is the lit-segment pattern for hex digit i (0..9, A, b, C, d, E, F).
  localparam logic [15:0][6:0] SEG_CODES = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } seq_state_t;

  // Returns {legal, digit}. Blank and unknown patterns come back as not legal.
  function automatic logic [4:0] seg7_to_hex(input logic [6:0] pattern);
    logic [4:0] res;
    res = 5'b0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_CODES[i]) res = {1'b1, 4'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_stabilizer.sv
// seg7_stabilizer: synchronises the asynchronous segment pattern, requires it to
// be stable for STABLE_CYCLES consecutive synced samples, and remembers the last
// accepted pattern so that the same pattern is never reported twice.
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   seg_in      in   raw segment pattern (async to clk)
//   accept_stb  out  1 in the cycle a new stable pattern is accepted
//   pattern     out  the synced pattern being accepted (valid with accept_stb)
module seg7_stabilizer
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  output logic       accept_stb,
  output logic [6:0] pattern
);

  localparam int CW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [6:0]    s1_q, s2_q, prev_q, accepted_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (s2_q != prev_q) cnt_d = CW'(1);
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
  end

  // Decided on the edge where the count reaches its limit, so a pattern settled
  // before edge 1 is accepted on edge STABLE_CYCLES+2.
  assign accept_stb = (cnt_d == CNT_MAX) && (s2_q != accepted_q);
  assign pattern    = s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= SEG_BLANK;
      s2_q       <= SEG_BLANK;
      prev_q     <= SEG_BLANK;
      accepted_q <= SEG_BLANK;
      cnt_q      <= '0;
    end else begin
      s1_q   <= seg_in;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      cnt_q  <= cnt_d;
      if (accept_stb) accepted_q <= s2_q;
    end
  end

endmodule

// File: rtl/seg7_readback_decoder.sv
// seg7_readback_decoder: recovers hex digits from a raw 7-segment pattern,
// flags illegal patterns and checks a modulo-MODULUS up-count sequence.
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   seg_in       in   segment pattern, bit0=a .. bit6=g, async to clk
//   digit_out    out  last accepted legal digit
//   digit_valid  out  1-cycle pulse on a newly accepted legal digit
//   digit_err    out  1-cycle pulse on a newly accepted illegal, non-blank pattern
//   blank        out  high while the last accepted pattern is blank
//   seq_ok       out  high while the last accepted digit followed the sequence
//   seq_err_cnt  out  saturating count of sequence violations
//
// state | meaning
// IDLE  | no reference digit yet (after reset or blank)
// TRACK | digit_out holds the reference for the next expected digit
module seg7_readback_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int MODULUS       = 8,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       seg_in,
  output logic [3:0]       digit_out,
  output logic             digit_valid,
  output logic             digit_err,
  output logic             blank,
  output logic             seq_ok,
  output logic [ERR_W-1:0] seq_err_cnt
);

  logic       accept_stb;
  logic [6:0] pattern;

  seg7_stabilizer #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_stab (
    .clk       (clk),
    .rst       (rst),
    .seg_in    (seg_in),
    .accept_stb(accept_stb),
    .pattern   (pattern)
  );

  logic [4:0]       dec;
  logic             legal;
  logic [3:0]       dec_digit;
  logic [4:0]       expected;
  logic             in_seq;

  seq_state_t       state_q, state_d;
  logic [3:0]       digit_q, digit_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             blank_q, blank_d;
  logic             ok_q, ok_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;

  assign dec       = seg7_to_hex(pattern);
  assign legal     = dec[4];
  assign dec_digit = dec[3:0];

  // The expected value is always < MODULUS, so any digit >= MODULUS mismatches.
  assign expected = ({1'b0, digit_q} + 5'd1) % 5'(MODULUS);
  assign in_seq   = ({1'b0, dec_digit} == expected);

  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    blank_d = blank_q;
    ok_d    = ok_q;
    cnt_d   = cnt_q;
    if (accept_stb) begin
      if (pattern == SEG_BLANK) begin
        blank_d = 1'b1;
        state_d = IDLE;
        ok_d    = 1'b0;
      end else if (!legal) begin
        err_d   = 1'b1;
        blank_d = 1'b0;
      end else begin
        valid_d = 1'b1;
        blank_d = 1'b0;
        digit_d = dec_digit;
        if (state_q == IDLE) begin
          ok_d    = 1'b0;
          state_d = TRACK;
        end else if (in_seq) begin
          ok_d = 1'b1;
        end else begin
          ok_d = 1'b0;
          if (cnt_q != '1) cnt_d = cnt_q + ERR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      digit_q <= 4'h0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      blank_q <= 1'b1;
      ok_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      blank_q <= blank_d;
      ok_q    <= ok_d;
      cnt_q   <= cnt_d;
    end
  end

  assign digit_out   = digit_q;
  assign digit_valid = valid_q;
  assign digit_err   = err_q;
  assign blank       = blank_q;
  assign seq_ok      = ok_q;
  assign seq_err_cnt = cnt_q;

endmodule

// File: tb/tb_seg7_readback_decoder.sv
module tb_seg7_readback_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg_in = 7'h00;
  logic [3:0] digit_out;
  logic       digit_valid;
  logic       digit_err;
  logic       blank;
  logic       seq_ok;
  logic [7:0] seq_err_cnt;

  int checks   = 0;
  int failures = 0;
  int n_valid  = 0;
  int n_err    = 0;

  seg7_readback_decoder #(
    .STABLE_CYCLES(4),
    .MODULUS      (8),
    .ERR_W        (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .digit_out  (digit_out),
    .digit_valid(digit_valid),
    .digit_err  (digit_err),
    .blank      (blank),
    .seq_ok     (seq_ok),
    .seq_err_cnt(seq_err_cnt)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle, so each 1-cycle pulse is seen once.
  always @(negedge clk) begin
    if (!rst) begin
      if (digit_valid) n_valid++;
      if (digit_err) n_err++;
    end
  end

  task automatic hold(input logic [6:0] p, input int n);
    seg_in = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({digit_out, digit_valid, digit_err, blank, seq_ok, seq_err_cnt} !==
        {4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL %s: got digit=%h v=%b e=%b blank=%b ok=%b cnt=%h, want 0 0 0 1 0 00",
               tag, digit_out, digit_valid, digit_err, blank, seq_ok, seq_err_cnt);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    seg_in = 7'h00;
    repeat (3) @(negedge clk);
    check_reset_values("reset_state");
    rst = 1'b0;
    seg_in = 7'h3F;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      checks++;
      if (digit_valid !== (k == 6)) begin
        failures++;
        $display("FAIL latency_edge%0d: digit_valid=%b want %b", k, digit_valid, (k == 6));
      end
      if (k == 6) begin
        checks++;
        if ({digit_out, blank, seq_ok} !== {4'h0, 1'b0, 1'b0}) begin
          failures++;
          $display("FAIL first_digit: digit=%h blank=%b ok=%b want 0 0 0",
                   digit_out, blank, seq_ok);
        end
      end
    end
    n_valid = 0;
    hold(7'h3F, 12);
    checks++;
    if (n_valid !== 0) begin
      failures++;
      $display("FAIL hold_no_repeat: pulses=%0d want 0", n_valid);
    end
  endtask

  task automatic test_sequence;
    logic [6:0] codes [9];
    logic [3:0] digs  [9];
    codes = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h3F};
    digs  = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h0};
    n_valid = 0;
    for (int i = 0; i < 9; i++) begin
      hold(codes[i], 10);
      if (i > 0) begin
        checks++;
        if ({digit_out, seq_ok} !== {digs[i], 1'b1}) begin
          failures++;
          $display("FAIL seq_step%0d: digit=%h ok=%b want %h 1", i, digit_out, seq_ok, digs[i]);
        end
      end
    end
    checks++;
    if (n_valid !== 8) begin
      failures++;
      $display("FAIL seq_pulses: got %0d want 8", n_valid);
    end
    checks++;
    if (seq_err_cnt !== 8'h00) begin
      failures++;
      $display("FAIL seq_errcnt: got %h want 00", seq_err_cnt);
    end
  endtask

  task automatic test_violation;
    hold(7'h06, 10);
    hold(7'h4F, 10);
    checks++;
    if ({digit_out, seq_ok, seq_err_cnt} !== {4'h3, 1'b0, 8'h01}) begin
      failures++;
      $display("FAIL skip_violation: digit=%h ok=%b cnt=%h want 3 0 01",
               digit_out, seq_ok, seq_err_cnt);
    end
    hold(7'h66, 10);
    checks++;
    if ({digit_out, seq_ok, seq_err_cnt} !== {4'h4, 1'b1, 8'h01}) begin
      failures++;
      $display("FAIL resume_seq: digit=%h ok=%b cnt=%h want 4 1 01",
               digit_out, seq_ok, seq_err_cnt);
    end
  endtask

  task automatic test_glitch;
    hold(7'h4F, 10);
    n_valid = 0;
    n_err = 0;
    hold(7'h5B, 3);
    hold(7'h4F, 10);
    checks++;
    if ({n_valid, n_err, 28'(digit_out)} !== {32'd0, 32'd0, 28'h3}) begin
      failures++;
      $display("FAIL glitch_reject: valid=%0d err=%0d digit=%h want 0 0 3",
               n_valid, n_err, digit_out);
    end
    hold(7'h7F, 10);
    checks++;
    if ({digit_out, seq_ok, seq_err_cnt} !== {4'h8, 1'b0, 8'h03} || n_valid !== 1) begin
      failures++;
      $display("FAIL over_modulus: digit=%h ok=%b cnt=%h pulses=%0d want 8 0 03 1",
               digit_out, seq_ok, seq_err_cnt, n_valid);
    end
  endtask

  task automatic test_illegal_blank;
    n_valid = 0;
    n_err = 0;
    hold(7'h01, 10);
    checks++;
    if ({n_err, n_valid} !== {32'd1, 32'd0} || digit_out !== 4'h8 || blank !== 1'b0) begin
      failures++;
      $display("FAIL illegal: err=%0d valid=%0d digit=%h blank=%b want 1 0 8 0",
               n_err, n_valid, digit_out, blank);
    end
    hold(7'h00, 10);
    checks++;
    if ({blank, seq_ok} !== 2'b10 || n_valid !== 0 || n_err !== 1) begin
      failures++;
      $display("FAIL blank: blank=%b ok=%b valid=%0d err=%0d want 1 0 0 1",
               blank, seq_ok, n_valid, n_err);
    end
    hold(7'h3F, 10);
    checks++;
    if ({digit_out, seq_ok, blank, seq_err_cnt} !== {4'h0, 1'b0, 1'b0, 8'h03}) begin
      failures++;
      $display("FAIL after_blank: digit=%h ok=%b blank=%b cnt=%h want 0 0 0 03",
               digit_out, seq_ok, blank, seq_err_cnt);
    end
    hold(7'h5B, 8);
    checks++;
    if (seq_err_cnt !== 8'h04) begin
      failures++;
      $display("FAIL first_violation_inc: cnt=%h want 04", seq_err_cnt);
    end
    hold(7'h3F, 8);
    for (int i = 0; i < 149; i++) begin
      hold(7'h5B, 8);
      hold(7'h3F, 8);
    end
    checks++;
    if (seq_err_cnt !== 8'hFF) begin
      failures++;
      $display("FAIL saturate: cnt=%h want FF", seq_err_cnt);
    end
  endtask

  task automatic test_rst_mid;
    hold(7'h6D, 10);
    checks++;
    if (digit_out !== 4'h5) begin
      failures++;
      $display("FAIL pre_rst_digit: digit=%h want 5", digit_out);
    end
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("mid_reset");
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      checks++;
      if (digit_valid !== (k == 6)) begin
        failures++;
        $display("FAIL reaccept_edge%0d: digit_valid=%b want %b", k, digit_valid, (k == 6));
      end
    end
    checks++;
    if ({digit_out, blank, seq_ok, seq_err_cnt} !== {4'h5, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL reaccept_state: digit=%h blank=%b ok=%b cnt=%h want 5 0 0 00",
               digit_out, blank, seq_ok, seq_err_cnt);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_sequence();
    test_violation();
    test_glitch();
    test_illegal_blank();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
